// File: rtl/column_counter_bank.sv
// -----------------------------------------------------------------------------
// column_counter_bank
//
// Bank of three bit-column population counters used in the partial-product
// reduction tree of the 6x6 array multiplier. Each lane counts the ones in
// its column: 3:2 lane (3 bits), 4:3 lane (4 bits) and 5:3 lane (5 bits).
// A combined count of all three lanes is also produced. All counts are
// zero-extended unsigned values wide enough that they never wrap.
//
// Parameters:
//   REG_OUT   1 = outputs registered (1-cycle latency, async reset clears)
//             0 = outputs combinational from inputs, out_valid = in_valid,
//                 rst has no effect on the outputs
//
// Optional feature (macro COMP_CIN_EN):
//   Adds a 3-bit carry-in 'cin' from the previous column that is added to
//   the 5:3 lane count (s53 range 0..12, s_all range 0..19).
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  column bits are valid this cycle
//   p32        in   3  3:2 lane column bits
//   p42        in   4  4:3 lane column bits
//   p53        in   5  5:3 lane column bits
//   cin        in   3  carry-in added to s53 (COMP_CIN_EN only)
//   out_valid  out  1  outputs hold a fresh result
//   s32        out  4  ones in p32
//   s42        out  4  ones in p42
//   s53        out  4  ones in p53 (+ cin with COMP_CIN_EN)
//   s_all      out  5  s32 + s42 + s53
// -----------------------------------------------------------------------------
module column_counter_bank #(
  parameter int REG_OUT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] p32,
  input  logic [3:0] p42,
  input  logic [4:0] p53,
`ifdef COMP_CIN_EN
  input  logic [2:0] cin,
`endif
  output logic       out_valid,
  output logic [3:0] s32,
  output logic [3:0] s42,
  output logic [3:0] s53,
  output logic [4:0] s_all
);

  // Next-state counts computed from the current input sample.
  logic [3:0] s32_d;
  logic [3:0] s42_d;
  logic [3:0] s53_d;
  logic [4:0] s_all_d;

  always_comb begin
    s32_d = '0;
    for (int i = 0; i < 3; i++) begin
      s32_d = s32_d + 4'(p32[i]);
    end
  end

  always_comb begin
    s42_d = '0;
    for (int i = 0; i < 4; i++) begin
      s42_d = s42_d + 4'(p42[i]);
    end
  end

  always_comb begin
    s53_d = '0;
    for (int i = 0; i < 5; i++) begin
      s53_d = s53_d + 4'(p53[i]);
    end
`ifdef COMP_CIN_EN
    // 5 + 7 = 12 max, still fits in 4 bits.
    s53_d = s53_d + 4'(cin);
`endif
  end

  // Widen before adding so the 0..19 range cannot wrap.
  assign s_all_d = 5'(s32_d) + 5'(s42_d) + 5'(s53_d);

  generate
    if (REG_OUT != 0) begin : g_reg
      logic       out_valid_q;
      logic [3:0] s32_q;
      logic [3:0] s42_q;
      logic [3:0] s53_q;
      logic [4:0] s_all_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          s32_q       <= '0;
          s42_q       <= '0;
          s53_q       <= '0;
          s_all_q     <= '0;
        end else begin
          out_valid_q <= in_valid;
          // Counts hold their last value on idle cycles.
          if (in_valid) begin
            s32_q   <= s32_d;
            s42_q   <= s42_d;
            s53_q   <= s53_d;
            s_all_q <= s_all_d;
          end
        end
      end

      assign out_valid = out_valid_q;
      assign s32       = s32_q;
      assign s42       = s42_q;
      assign s53       = s53_q;
      assign s_all     = s_all_q;
    end else begin : g_comb
      // Clock and reset are not used in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign out_valid = in_valid;
      assign s32       = s32_d;
      assign s42       = s42_d;
      assign s53       = s53_d;
      assign s_all     = s_all_d;
    end
  endgenerate

endmodule

// File: tb/tb_column_counter_bank.sv
// -----------------------------------------------------------------------------
// tb_column_counter_bank
//
// Randomized and directed stimulus for column_counter_bank (REG_OUT=1),
// checked against a behavioural model that counts ones with $countones and
// tracks the registered output state. Define COMP_CIN_EN to exercise cin.
// -----------------------------------------------------------------------------
module tb_column_counter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] p32;
  logic [3:0] p42;
  logic [4:0] p53;
`ifdef COMP_CIN_EN
  logic [2:0] cin;
`endif
  logic       out_valid;
  logic [3:0] s32;
  logic [3:0] s42;
  logic [3:0] s53;
  logic [4:0] s_all;

  int total = 0;
  int bad   = 0;

  // Model of what the outputs should show.
  int m_valid = 0;
  int m_s32   = 0;
  int m_s42   = 0;
  int m_s53   = 0;
  int m_all   = 0;

  column_counter_bank #(.REG_OUT(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .p32       (p32),
    .p42       (p42),
    .p53       (p53),
`ifdef COMP_CIN_EN
    .cin       (cin),
`endif
    .out_valid (out_valid),
    .s32       (s32),
    .s42       (s42),
    .s53       (s53),
    .s_all     (s_all)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check_val({tag, ".s32"},   32'(s32),       32'(m_s32));
    check_val({tag, ".s42"},   32'(s42),       32'(m_s42));
    check_val({tag, ".s53"},   32'(s53),       32'(m_s53));
    check_val({tag, ".s_all"}, 32'(s_all),     32'(m_all));
  endtask

  // Drive one sample, clock it in, update the model, then check.
  task automatic apply(input string tag, input logic v, input logic [2:0] a,
                       input logic [3:0] b, input logic [4:0] c, input logic [2:0] ci);
    int extra;
    in_valid = v;
    p32 = a;
    p42 = b;
    p53 = c;
    extra = 0;
`ifdef COMP_CIN_EN
    cin = ci;
    extra = int'(ci);
`endif
    @(posedge clk);
    m_valid = v ? 1 : 0;
    if (v) begin
      m_s32 = $countones(a);
      m_s42 = $countones(b);
      m_s53 = $countones(c) + extra;
      m_all = m_s32 + m_s42 + m_s53;
    end
    #1;
    check_all(tag);
    $display("%s: v=%0d p32=%b p42=%b p53=%b cin=%0d -> valid=%0d s32=%0d s42=%0d s53=%0d s_all=%0d",
             tag, v, a, b, c, ci, out_valid, s32, s42, s53, s_all);
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_s32   = 0;
    m_s42   = 0;
    m_s53   = 0;
    m_all   = 0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    p32      = '0;
    p42      = '0;
    p53      = '0;
`ifdef COMP_CIN_EN
    cin      = '0;
`endif
    #1;
    check_all("reset_initial");
    $display("reset_initial: valid=%0d s_all=%0d", out_valid, s_all);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // All ones, zeros, sparse.
    apply("all_ones", 1'b1, 3'b111, 4'b1111, 5'b11111, 3'd0);
    apply("all_zero", 1'b1, 3'b000, 4'b0000, 5'b00000, 3'd0);
    apply("sparse",   1'b1, 3'b010, 4'b1001, 5'b10101, 3'd0);

    // Asynchronous reset mid-cycle with nonzero outputs.
    apply("pre_rst", 1'b1, 3'b111, 4'b1111, 5'b11111, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    $display("async_rst: valid=%0d s_all=%0d", out_valid, s_all);
    // A valid sample presented during reset is discarded.
    in_valid = 1'b1;
    p32 = 3'b111;
    p42 = 4'b1111;
    p53 = 5'b11111;
    @(posedge clk);
    #1;
    check_all("rst_discard");
    $display("rst_discard: valid=%0d s_all=%0d", out_valid, s_all);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_all("rst_release");
    $display("rst_release: valid=%0d s_all=%0d", out_valid, s_all);
    @(posedge clk);
    #1;
    apply("first_after_rst", 1'b1, 3'b101, 4'b0111, 5'b01100, 3'd0);

    // Back-to-back sweep of every p53 value with p42/p32 cycling.
    for (int i = 0; i < 32; i++) begin
      apply($sformatf("sweep%0d", i), 1'b1, 3'(i % 8), 4'(i % 16), 5'(i), 3'(i % 8));
    end

    // Hold: changing inputs with in_valid low.
    for (int i = 0; i < 4; i++) begin
      apply($sformatf("hold%0d", i), 1'b0, 3'($urandom), 4'($urandom), 5'($urandom), 3'($urandom));
    end
    apply("resume", 1'b1, 3'b011, 4'b1110, 5'b11011, 3'd2);

`ifdef COMP_CIN_EN
    apply("cin_max",  1'b1, 3'b111, 4'b1111, 5'b11111, 3'b111);
    apply("cin_only", 1'b1, 3'b000, 4'b0000, 5'b00000, 3'b011);
`endif

    // Random traffic with random valid.
    for (int i = 0; i < 200; i++) begin
      apply($sformatf("rand%0d", i), 1'($urandom_range(0, 3) != 0), 3'($urandom),
            4'($urandom), 5'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
